// File: rtl/yarp_pkg.sv
// Shared types for the YARP ALU arbiter: ALU op encodings, arbiter FSM states
// and the requester count.
package yarp_pkg;

  localparam int YARP_ALU_NREQ = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SLL  = 4'h2,
    OP_SRL  = 4'h3,
    OP_SRA  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_XOR  = 4'h7,
    OP_SLTU = 4'h8,
    OP_SLT  = 4'h9
  } alu_op_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/yarp_execute.sv
// Combinational 32-bit ALU. Any op code outside alu_op_e produces zero.
module yarp_execute
  import yarp_pkg::*;
(
  input  logic [31:0] opr_a_i,
  input  logic [31:0] opr_b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] alu_res_o
);

  logic [4:0] shamt;
  assign shamt = opr_b_i[4:0];

  always_comb begin
    alu_res_o = 32'h0;
    case (op_i)
      OP_ADD:  alu_res_o = opr_a_i + opr_b_i;
      OP_SUB:  alu_res_o = opr_a_i - opr_b_i;
      OP_SLL:  alu_res_o = opr_a_i << shamt;
      OP_SRL:  alu_res_o = opr_a_i >> shamt;
      OP_SRA:  alu_res_o = $unsigned($signed(opr_a_i) >>> shamt);
      OP_OR:   alu_res_o = opr_a_i | opr_b_i;
      OP_AND:  alu_res_o = opr_a_i & opr_b_i;
      OP_XOR:  alu_res_o = opr_a_i ^ opr_b_i;
      OP_SLTU: alu_res_o = {31'h0, opr_a_i < opr_b_i};
      OP_SLT:  alu_res_o = {31'h0, $signed(opr_a_i) < $signed(opr_b_i)};
      default: alu_res_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/yarp_alu_arbiter.sv
// Round-robin sharing of one ALU between core (0) and auxiliary (1) requesters,
// with a single registered result slot that sustains one result per cycle.
module yarp_alu_arbiter
  import yarp_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [YARP_ALU_NREQ-1:0]         req_valid_i,
  output logic [YARP_ALU_NREQ-1:0]         req_ready_o,
  input  logic [YARP_ALU_NREQ-1:0][3:0]    req_op_i,
  input  logic [YARP_ALU_NREQ-1:0][31:0]   req_a_i,
  input  logic [YARP_ALU_NREQ-1:0][31:0]   req_b_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [31:0]                      rsp_res_o,
  output logic                             rsp_id_o
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic        rsp_id_q, rsp_id_d;
  logic        can_accept, accept, gnt_idx;
  logic [31:0] alu_res;

  // Contested cycles go to the requester that did not win last time.
  assign gnt_idx    = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
  assign can_accept = (state_q == ARB_IDLE) || rsp_ready_i;
  assign accept     = can_accept && (|req_valid_i);

  for (genvar i = 0; i < YARP_ALU_NREQ; i++) begin : g_ready
    assign req_ready_o[i] = accept && (gnt_idx == 1'(i));
  end

  yarp_execute u_execute (
    .opr_a_i   (req_a_i[gnt_idx]),
    .opr_b_i   (req_b_i[gnt_idx]),
    .op_i      (req_op_i[gnt_idx]),
    .alu_res_o (alu_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_HOLD;
      ARB_HOLD: if (rsp_ready_i && !accept) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_o = (state_q == ARB_HOLD);
    rsp_res_o   = rsp_res_q;
    rsp_id_o    = rsp_id_q;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_res_d    = rsp_res_q;
    rsp_id_d     = rsp_id_q;
    if (accept) begin
      last_grant_d = gnt_idx;
      rsp_res_d    = alu_res;
      rsp_id_d     = gnt_idx;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rsp_res_q    <= 32'h0;
      rsp_id_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_res_q    <= rsp_res_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_yarp_alu_arbiter.sv
// Scoreboard bench for yarp_alu_arbiter: a negedge monitor models grants and
// queues expected results; directed steps add constant checks.
module tb_yarp_alu_arbiter;
  import yarp_pkg::*;

  logic              clk;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_op;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_res;
  logic              rsp_id;

  typedef struct {
    logic        id;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic m_hold = 1'b0;
  logic m_last = 1'b1;

  yarp_alu_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_res_o   (rsp_res),
    .rsp_id_o    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    case (op)
      4'h0: return a + b;
      4'h1: return a + ~b + 32'd1;
      4'h2: return a << b[4:0];
      4'h3: return a >> b[4:0];
      4'h4: begin
        ext = {{32{a[31]}}, a} >> b[4:0];
        return ext[31:0];
      end
      4'h5: return a | b;
      4'h6: return a & b;
      4'h7: return a ^ b;
      4'h8: return (a < b) ? 32'd1 : 32'd0;
      4'h9: return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  // Mid-cycle monitor: inputs and outputs are both settled here.
  initial begin
    logic       can, acc, g;
    logic [1:0] exp_rdy;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_hold = 1'b0;
        m_last = 1'b1;
        sb.delete();
      end else begin
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_hold});
        if (m_hold) begin
          if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
          else begin
            e = sb[0];
            chk("rsp_id", {31'h0, rsp_id}, {31'h0, e.id});
            chk("rsp_res", rsp_res, e.res);
            if (rsp_ready) void'(sb.pop_front());
          end
        end
        can     = !m_hold || rsp_ready;
        g       = (req_valid == 2'b11) ? !m_last : req_valid[1];
        acc     = can && (|req_valid);
        exp_rdy = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", {30'h0, req_ready}, {30'h0, exp_rdy});
        if (acc) begin
          e.id  = g;
          e.res = alu_ref(req_op[g], req_a[g], req_b[g]);
          sb.push_back(e);
          m_last = g;
        end
        m_hold = acc || (m_hold && !rsp_ready);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_res", rsp_res, 32'd0);
    chk("rst_id", {31'h0, rsp_id}, 32'd0);
    step(); step();
    reset_n = 1'b1;

    // Single core request: 5 + 7
    req_valid = 2'b01; req_op[0] = OP_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7; rsp_ready = 1'b1;
    #2 chk("add_ready", {30'h0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    #2;
    chk("add_valid", {31'h0, rsp_valid}, 32'd1);
    chk("add_res", rsp_res, 32'd12);
    chk("add_id", {31'h0, rsp_id}, 32'd0);
    step();

    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;

    // Both requesters contend every cycle: grants must alternate from 0
    req_valid = 2'b11;
    req_op[0] = OP_SUB; req_a[0] = 32'd10;   req_b[0] = 32'd3;
    req_op[1] = OP_XOR; req_a[1] = 32'hF0;   req_b[1] = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      #2 chk("rr_grant", {30'h0, req_ready}, (i % 2) ? 32'd2 : 32'd1);
      if (i > 0) chk("rr_res", rsp_res, (i % 2) ? 32'd7 : 32'hFF);
      step();
    end

    // Back-pressure: held result stays put, aux waits, then wins same cycle
    req_valid = 2'b01; req_op[0] = OP_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
    #2 chk("bp_accept", {30'h0, req_ready}, 32'd1);
    step();
    req_valid = 2'b10; req_op[1] = OP_XOR; req_a[1] = 32'hAA; req_b[1] = 32'h55;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_ready", {30'h0, req_ready}, 32'd0);
      chk("bp_res", rsp_res, 32'd3);
      chk("bp_valid", {31'h0, rsp_valid}, 32'd1);
      step();
    end
    rsp_ready = 1'b1;
    #2 chk("bp_release", {30'h0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    #2;
    chk("bp_res1", rsp_res, 32'hFF);
    chk("bp_id1", {31'h0, rsp_id}, 32'd1);
    step();

    // Signed compare and arithmetic shift
    req_valid = 2'b01; req_op[0] = OP_SLT; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1;
    step();
    req_op[0] = OP_SRA; req_a[0] = 32'h8000_0000; req_b[0] = 32'd4;
    #2 chk("slt_res", rsp_res, 32'd1);
    step();
    req_valid = 2'b00;
    #2 chk("sra_res", rsp_res, 32'hF800_0000);
    step();

    // Illegal op yields zero; async reset discards the held result
    req_valid = 2'b01; req_op[0] = 4'hF; req_a[0] = 32'd123; req_b[0] = 32'd456;
    step();
    req_valid = 2'b00; rsp_ready = 1'b0;
    #1;
    chk("ill_valid", {31'h0, rsp_valid}, 32'd1);
    chk("ill_res", rsp_res, 32'd0);
    #1 reset_n = 1'b0;
    #1 chk("arst_valid", {31'h0, rsp_valid}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    req_op[0] = OP_AND; req_a[0] = 32'hF0F0; req_b[0] = 32'hFF00;
    req_op[1] = OP_OR;  req_a[1] = 32'h1;    req_b[1] = 32'h2;
    #2 chk("post_rst_grant", {30'h0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    #2 chk("post_rst_res", rsp_res, 32'hF000);
    step(); step(); step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
